// File: rtl/wb_queue_if.sv
// Writeback-queue bus: producer enqueue handshake, register-file write port,
// in-flight register mask and decode-stage bypass lookups.
interface wb_queue_if #(parameter int XLEN = 32);
  logic            enq_valid_i;
  logic [4:0]      enq_rd_i;
  logic [XLEN-1:0] enq_data_i;
  logic            enq_ready_o;
  logic            stall_i;
  logic [4:0]      wrr_o;
  logic [XLEN-1:0] wrdata_o;
  logic            is_regwrite_o;
  logic [31:0]     pending_o;
  logic [4:0]      rs1_i;
  logic [4:0]      rs2_i;
  logic            fwd1_hit_o;
  logic            fwd2_hit_o;
  logic [XLEN-1:0] fwd1_data_o;
  logic [XLEN-1:0] fwd2_data_o;

  // Handshake: a request transfers on the rising edge where enq_valid_i and
  // enq_ready_o are both high; the producer holds rd/data stable until then.
  modport master (
    output enq_valid_i, enq_rd_i, enq_data_i, stall_i, rs1_i, rs2_i,
    input  enq_ready_o, wrr_o, wrdata_o, is_regwrite_o, pending_o,
           fwd1_hit_o, fwd2_hit_o, fwd1_data_o, fwd2_data_o
  );

  modport slave (
    input  enq_valid_i, enq_rd_i, enq_data_i, stall_i, rs1_i, rs2_i,
    output enq_ready_o, wrr_o, wrdata_o, is_regwrite_o, pending_o,
           fwd1_hit_o, fwd2_hit_o, fwd1_data_o, fwd2_data_o
  );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue: buffers register-file writes and drains one per cycle.
// Define WB_QUEUE_BYPASS_EN to build the youngest-entry bypass search.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  wb_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW:0]     count;
  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [31:0]     pending;
  logic            enq_fire;
  logic            enq_push;
  logic            drain;
  logic            not_empty;

  function automatic logic [AW-1:0] age_of(input int i, input logic [AW-1:0] h);
    age_of = AW'(i) - h;
  endfunction

  assign not_empty       = (count != '0);
  assign bus.enq_ready_o = (count != (AW+1)'(DEPTH));
  assign enq_fire        = bus.enq_valid_i && bus.enq_ready_o;
  // x0 writes complete the handshake but never occupy an entry.
  assign enq_push        = enq_fire && (bus.enq_rd_i != 5'd0);
  assign drain           = not_empty && !bus.stall_i;

  assign bus.is_regwrite_o = drain;
  assign bus.wrr_o         = not_empty ? rd_q[head]   : 5'd0;
  assign bus.wrdata_o      = not_empty ? data_q[head] : '0;

  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, age_of(i, head)} < count);
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) pending[rd_q[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end
  assign bus.pending_o = pending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (enq_push) begin
        rd_q[tail]   <= bus.enq_rd_i;
        data_q[tail] <= bus.enq_data_i;
        tail         <= tail + AW'(1);
      end
      if (drain) head <= head + AW'(1);
      if (enq_push && !drain)      count <= count + (AW+1)'(1);
      else if (!enq_push && drain) count <= count - (AW+1)'(1);
    end
  end

`ifdef WB_QUEUE_BYPASS_EN
  // Walk oldest to youngest so the last match (closest to tail) wins.
  function automatic logic [XLEN:0] search(input logic [4:0] rs);
    logic [XLEN:0]   r;
    logic [AW-1:0]   idx;
    r = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + AW'(k);
      if (((AW+1)'(k) < count) && (rs != 5'd0) && (rd_q[idx] == rs))
        r = {1'b1, data_q[idx]};
    end
    return r;
  endfunction

  assign {bus.fwd1_hit_o, bus.fwd1_data_o} = search(bus.rs1_i);
  assign {bus.fwd2_hit_o, bus.fwd2_data_o} = search(bus.rs2_i);
`else
  logic unused_rs;
  assign unused_rs       = ^{bus.rs1_i, bus.rs2_i};
  assign bus.fwd1_hit_o  = 1'b0;
  assign bus.fwd2_hit_o  = 1'b0;
  assign bus.fwd1_data_o = '0;
  assign bus.fwd2_data_o = '0;
`endif
endmodule

// File: doc/wb_queue.md
# wb_queue

Writeback queue for the RISC-V core: buffers register-file write requests from the execute/memory stages and drains them, one per cycle, into the register file's single write port. It tracks which architectural registers have writes in flight and optionally forwards the youngest queued value to the decode-stage operand reads. It sits between the producers (ALU/load unit) and the register file's write interface (register select, write data, write enable).

## Interface
- `DEPTH`, 4: number of queue entries; power of two, ≥2.
- `XLEN`, 32: data width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `enq_valid_i`  in  1  producer has a write request.
- `enq_rd_i`  in  5  destination register.
- `enq_data_i`  in  XLEN  write data.
- `enq_ready_o`  out  1  queue can accept; high when count < DEPTH.
- `stall_i`  in  1  register-file write port unavailable this cycle; inhibits drain.
- `wrr_o`  out  5  register-file write register (head rd).
- `wrdata_o`  out  XLEN  register-file write data (head data).
- `is_regwrite_o`  out  1  register-file write enable.
- `pending_o`  out  32  bit r set iff a queued entry targets xr.
- `rs1_i`, `rs2_i`  in  5  bypass lookup registers.
- `fwd1_hit_o`, `fwd2_hit_o`  out  1  lookup matched a queued entry.
- `fwd1_data_o`, `fwd2_data_o`  out  XLEN  data of youngest matching entry.

## Operation
- Circular buffer: head pointer, tail pointer (log2 DEPTH bits, wrap naturally), count (log2 DEPTH + 1 bits).
- Enqueue on edge when `enq_valid_i && enq_ready_o`; entry written at tail, tail++.
- Requests with `enq_rd_i == 0` are handshaken (accepted) but discarded: no entry, no count change.
- `enq_ready_o = (count != DEPTH)`, independent of same-cycle drain: no enqueue when full, even while draining.
- Drain: `is_regwrite_o = (count != 0) && !stall_i`; `wrr_o`/`wrdata_o` show head entry whenever count ≠ 0, else 0. On edge with `is_regwrite_o` high, head++.
- Simultaneous enqueue and drain: count unchanged; both pointers advance.
- Entries drain strictly in enqueue order; multiple entries to the same rd are all written, in order.
- `pending_o`: OR over valid entries of one-hot(rd); bit 0 always 0. Derived from registered state only.
- Bypass: for each lookup port, search valid entries; hit = any match with rs ≠ 0; data = youngest (closest to tail) match. rs = 0 → no hit, data 0. Miss → data 0. Same-cycle incoming enqueue is not searched.

## Timing
- Reset (`rst_n` low at edge): count, head, tail cleared; contents cleared to 0. Next cycle: `enq_ready_o`=1, `is_regwrite_o`=0, `wrr_o`=0, `wrdata_o`=0, `pending_o`=0, all hit/data outputs 0.
- Reset asserted mid-operation discards all queued writes; none reach the write port afterwards.
- Enqueue latency: accepted at edge N → visible on write port, `pending_o`, bypass in cycle N+1; register file updated at edge N+1 (absent stall).
- Drain outputs and bypass are combinational from queue state; no added latency.
- Throughput: one enqueue and one drain per cycle sustained.
- `stall_i` holds head and outputs stable (enable low) for every stalled cycle.

## Configuration
- `WB_QUEUE_BYPASS_EN` defined: bypass search logic and outputs as above.
- Not defined: no search logic; `fwd1_hit_o`, `fwd2_hit_o` tied 0, `fwd1_data_o`, `fwd2_data_o` tied 0. Queue, drain and `pending_o` unchanged.

## Test plan
- Reset then single enqueue rd=5, data=0xDEADBEEF at edge N → cycle N+1: `is_regwrite_o`=1, `wrr_o`=5, `wrdata_o`=0xDEADBEEF, `pending_o`=0x20; cycle N+2: queue empty, `pending_o`=0.
- `stall_i`=1, enqueue rd=1..4 (DEPTH=4) → `enq_ready_o`=0 after 4th; 5th request held; release stall → writes x1..x4 in order on consecutive cycles, ready returns cycle after first drain.
- Full queue, `stall_i`=0, `enq_valid_i`=1 → no enqueue that cycle despite drain; count goes 4→3, then sustained one-in/one-out at count 3.
- Enqueue rd=0, data=0x1234 → handshake completes, no write port activity, `pending_o`=0.
- Bypass (macro defined): stall, enqueue rd=7 data=0x11 then rd=7 data=0x22; `rs1_i`=7 → hit, 0x22; `rs2_i`=0 → no hit; without macro both hits 0.
- Reset mid-drain with 3 entries queued → next cycle `is_regwrite_o`=0, `pending_o`=0, no further writes.
